// File: rtl/key_conditioner_pkg.sv
// Shared constants and helpers for the pushbutton conditioner.
// Default timing assumes the 50 MHz board clock.
package key_conditioner_pkg;

    localparam int KC_CLK_HZ                = 50_000_000;
    localparam int KC_DEFAULT_DEBOUNCE      = KC_CLK_HZ / 50;
    localparam int KC_DEFAULT_REPEAT_DELAY  = KC_CLK_HZ / 2;
    localparam int KC_DEFAULT_REPEAT_PERIOD = KC_CLK_HZ / 10;

    function automatic int kc_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, stability-counter debounce, press/release pulses.
// Auto-repeat on held keys is added when KEY_CONDITIONER_REPEAT_EN is defined.
module key_channel
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KC_DEFAULT_DEBOUNCE,
    parameter int REPEAT_DELAY    = KC_DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = KC_DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic resetn,
    input  logic key_n,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("key_channel: timing parameters must be at least 1");
    end

    logic             sync_p0;
    logic             sync_p1;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             rep_fire;

    assign s      = ~sync_p1;
    assign accept = (s != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_p0       <= 1'b1;
            sync_p1       <= 1'b1;
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            // stage p0/p1: synchronise the raw pin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
            // debounce: any return to the accepted level restarts the count
            if (s == level) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= '0;
                level <= s;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
            press         <= (accept && s) || rep_fire;
            release_pulse <= accept && !s;
        end
    end

`ifdef KEY_CONDITIONER_REPEAT_EN
    localparam int HOLD_W = $clog2(kc_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [HOLD_W-1:0] HOLD_DELAY  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_PERIOD = HOLD_W'(REPEAT_PERIOD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

    logic [HOLD_W-1:0] hold;
    logic              repeating;

    // A release acceptance wins over a repeat landing in the same cycle.
    assign rep_fire = level && !accept &&
                      (hold == (repeating ? HOLD_PERIOD : HOLD_DELAY));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold      <= '0;
            repeating <= 1'b0;
        end else if (!level || accept) begin
            hold      <= '0;
            repeating <= 1'b0;
        end else if (rep_fire) begin
            hold      <= '0;
            repeating <= 1'b1;
        end else begin
            hold <= hold + HOLD_ONE;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Conditions WIDTH active-low pushbuttons into debounced levels and pulses.
// Optional auto-repeat: KEY_CONDITIONER_REPEAT_EN. "release" is a reserved word, hence release_pulse.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = KC_DEFAULT_DEBOUNCE,
    parameter int REPEAT_DELAY    = KC_DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = KC_DEFAULT_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] keys_n,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk          (clk),
            .resetn       (resetn),
            .key_n        (keys_n[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Expectations follow KEY_CONDITIONER_REPEAT_EN when it is defined for the build.
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] keys_n;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] release_pulse;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] keys_n;
        int         cycles;
        logic [3:0] exp_level;
        logic [3:0] exp_press;
        logic [3:0] exp_rel;
    } step_t;

    step_t      steps[$];
    logic [3:0] cur_level;

    always #5 clk = ~clk;

    key_conditioner #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .keys_n       (keys_n),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges; pulses must stay low and level hold until the final edge.
    task automatic expect_cycles(input int n, input logic [3:0] lvl_before,
                                 input logic [3:0] lvl_final, input logic [3:0] p_final,
                                 input logic [3:0] r_final, input string tag);
        for (int c = 1; c <= n; c++) begin
            tick();
            if (c == n) begin
                check($sformatf("%s.c%0d.level", tag, c), level, lvl_final);
                check($sformatf("%s.c%0d.press", tag, c), press, p_final);
                check($sformatf("%s.c%0d.release", tag, c), release_pulse, r_final);
            end else begin
                check($sformatf("%s.c%0d.level", tag, c), level, lvl_before);
                check($sformatf("%s.c%0d.press", tag, c), press, 4'b0000);
                check($sformatf("%s.c%0d.release", tag, c), release_pulse, 4'b0000);
            end
        end
    endtask

    task automatic run_step(input step_t st, input string tag);
        @(negedge clk);
        keys_n = st.keys_n;
        expect_cycles(st.cycles, cur_level, st.exp_level, st.exp_press, st.exp_rel, tag);
        cur_level = st.exp_level;
    endtask

    function automatic bit rep_press_at(input int i);
`ifdef KEY_CONDITIONER_REPEAT_EN
        return i inside {6, 16, 21, 26, 31, 36, 41};
`else
        return i == 6;
`endif
    endfunction

    initial begin
        resetn = 1'b0;
        keys_n = 4'b0000;

        // all keys held through reset: outputs stay cleared
        expect_cycles(4, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "in_reset");
        @(negedge clk);
        resetn = 1'b1;
        expect_cycles(6, 4'b0000, 4'b1111, 4'b1111, 4'b0000, "post_reset");
        expect_cycles(1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, "post_reset_hold");
        cur_level = 4'b1111;

        steps.push_back('{4'b1111, 6, 4'b0000, 4'b0000, 4'b1111});
        steps.push_back('{4'b1110, 6, 4'b0001, 4'b0001, 4'b0000});
        steps.push_back('{4'b1111, 6, 4'b0000, 4'b0000, 4'b0001});
        for (int b = 0; b < 10; b++)
            steps.push_back('{(b % 2 == 0) ? 4'b1110 : 4'b1111, 3, 4'b0000, 4'b0000, 4'b0000});
        steps.push_back('{4'b1110, 6, 4'b0001, 4'b0001, 4'b0000});
        steps.push_back('{4'b1111, 6, 4'b0000, 4'b0000, 4'b0001});
        steps.push_back('{4'b0101, 6, 4'b1010, 4'b1010, 4'b0000});
        steps.push_back('{4'b1111, 6, 4'b0000, 4'b0000, 4'b1010});

        foreach (steps[k])
            run_step(steps[k], $sformatf("step%0d", k));

        // reset while key 0 is 3 counts into its debounce and key 3 is accepted
        run_step('{4'b0111, 6, 4'b1000, 4'b1000, 4'b0000}, "mid_k3");
        @(negedge clk);
        keys_n = 4'b0110;
        expect_cycles(5, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "mid_count");
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid_async.level", level, 4'b0000);
        check("mid_async.press", press, 4'b0000);
        check("mid_async.release", release_pulse, 4'b0000);
        expect_cycles(3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "mid_in_reset");
        @(negedge clk);
        resetn = 1'b1;
        expect_cycles(6, 4'b0000, 4'b1001, 4'b1001, 4'b0000, "mid_reaccept");
        cur_level = 4'b1001;
        run_step('{4'b1111, 6, 4'b0000, 4'b0000, 4'b1001}, "mid_release");

        // key 2 held for 40 cycles
        @(negedge clk);
        keys_n = 4'b1011;
        for (int i = 1; i <= 60; i++) begin
            tick();
            check($sformatf("hold.c%0d.press", i), press, rep_press_at(i) ? 4'b0100 : 4'b0000);
            check($sformatf("hold.c%0d.release", i), release_pulse, (i == 46) ? 4'b0100 : 4'b0000);
            check($sformatf("hold.c%0d.level", i), level, (i >= 6 && i < 46) ? 4'b0100 : 4'b0000);
            if (i == 40) begin
                @(negedge clk);
                keys_n = 4'b1111;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
